// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, 2-flop column sync, press/release debounce, one pulse per digit.
// Optional '*' clear pulse on key_clear when KEYPAD_CLEAR_EN is defined (default: key_clear tied low).
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [3:0] user_digit,
  output logic       user_latch,
  output logic       key_clear,
  output logic       key_busy
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state_reg;
  logic [3:0]       col_meta_reg;
  logic [3:0]       col_s_reg;
  logic [1:0]       row_idx_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DEB_W-1:0] deb_reg;
  logic [3:0]       col_code_reg;
  logic [3:0]       digit_reg;
  logic             latch_reg;
  logic             busy_reg;

  logic [3:0] col_zero;
  logic       single_zero;
  logic [1:0] col_idx;
  logic       key_is_digit;
  logic [3:0] key_digit;

  // Row drive and active-low column sense are both decoded bit-per-bit.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bits
      assign row_n[gi]    = (row_idx_reg != 2'(gi));
      assign col_zero[gi] = ~col_s_reg[gi];
    end
  endgenerate

  // Anything other than exactly one low column is ghosting or idle.
  assign single_zero = $onehot(col_zero);

  always_comb begin
    col_idx = 2'd0;
    case (col_code_reg)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    key_is_digit = 1'b1;
    key_digit    = 4'd0;
    case ({row_idx_reg, col_idx})
      4'h0:    key_digit = 4'd1;
      4'h1:    key_digit = 4'd2;
      4'h2:    key_digit = 4'd3;
      4'h4:    key_digit = 4'd4;
      4'h5:    key_digit = 4'd5;
      4'h6:    key_digit = 4'd6;
      4'h8:    key_digit = 4'd7;
      4'h9:    key_digit = 4'd8;
      4'hA:    key_digit = 4'd9;
      4'hD:    key_digit = 4'd0;
      default: key_is_digit = 1'b0;
    endcase
  end

`ifdef KEYPAD_CLEAR_EN
  logic clear_reg;
  logic key_is_star;
  assign key_is_star = ({row_idx_reg, col_idx} == 4'hC);
  assign key_clear   = clear_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clear_reg <= 1'b0;
    end else begin
      clear_reg <= (state_reg == DEBOUNCE) && (col_s_reg == col_code_reg) &&
                   (deb_reg == DEB_LAST) && key_is_star;
    end
  end
`else
  assign key_clear = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= SCAN;
      col_meta_reg <= 4'b1111;
      col_s_reg    <= 4'b1111;
      row_idx_reg  <= 2'd0;
      div_reg      <= '0;
      deb_reg      <= '0;
      col_code_reg <= 4'b1111;
      digit_reg    <= 4'd0;
      latch_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      col_meta_reg <= col_n;
      col_s_reg    <= col_meta_reg;
      latch_reg    <= 1'b0;
      case (state_reg)
        SCAN: begin
          if (single_zero) begin
            col_code_reg <= col_s_reg;
            deb_reg      <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= DEBOUNCE;
          end else if (div_reg == DIV_LAST) begin
            div_reg     <= '0;
            row_idx_reg <= row_idx_reg + 2'd1;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (col_s_reg != col_code_reg) begin
            // Bounce or second key: resume scanning the same row from a fresh divider.
            div_reg   <= '0;
            busy_reg  <= 1'b0;
            state_reg <= SCAN;
          end else if (deb_reg == DEB_LAST) begin
            state_reg <= PRESSED;
            if (key_is_digit) begin
              digit_reg <= key_digit;
              latch_reg <= 1'b1;
            end
          end else begin
            deb_reg <= deb_reg + 1'b1;
          end
        end
        PRESSED: begin
          deb_reg   <= '0;
          state_reg <= RELEASE;
        end
        RELEASE: begin
          if (col_s_reg == 4'b1111) begin
            if (deb_reg == DEB_LAST) begin
              // Move past the released row so one key cannot starve the others.
              row_idx_reg <= row_idx_reg + 2'd1;
              div_reg     <= '0;
              busy_reg    <= 1'b0;
              state_reg   <= SCAN;
            end else begin
              deb_reg <= deb_reg + 1'b1;
            end
          end else begin
            deb_reg <= '0;
          end
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  assign user_digit = digit_reg;
  assign user_latch = latch_reg;
  assign key_busy   = busy_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8 and a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] user_digit;
  logic       user_latch;
  logic       key_clear;
  logic       key_busy;

  logic [15:0] keys = '0;  // bit r*4+c = key at row r, column c held down

  int   cmp_cnt = 0;
  int   fail_cnt = 0;
  int   latch_cnt = 0;
  int   clear_cnt = 0;
  logic [3:0] last_digit = 4'd0;
  bit   overlap_seen = 1'b0;
  bit   consec_seen = 1'b0;
  bit   prev_pulse = 1'b0;

`ifdef KEYPAD_CLEAR_EN
  localparam int EXP_CLEAR = 1;
`else
  localparam int EXP_CLEAR = 0;
`endif

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_n(row_n),
    .col_n(col_n),
    .user_digit(user_digit),
    .user_latch(user_latch),
    .key_clear(key_clear),
    .key_busy(key_busy)
  );

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (user_latch) begin
      latch_cnt  = latch_cnt + 1;
      last_digit = user_digit;
    end
    if (key_clear) clear_cnt = clear_cnt + 1;
    if (user_latch && key_clear) overlap_seen = 1'b1;
    if ((user_latch || key_clear) && prev_pulse) consec_seen = 1'b1;
    prev_pulse = user_latch || key_clear;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!key_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_row(input logic [3:0] row, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (row_n == row) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    logic [3:0] ones;
    reset = 1'b0;
    keys  = '0;
    repeat (3) tick();
    cmp_cnt++; if (row_n !== 4'b1110) begin fail_cnt++; $display("FAIL reset_row_n: got %b expected 1110", row_n); end
    cmp_cnt++; if (user_digit !== 4'd0) begin fail_cnt++; $display("FAIL reset_digit: got %0d expected 0", user_digit); end
    cmp_cnt++; if (user_latch !== 1'b0) begin fail_cnt++; $display("FAIL reset_latch: got %b expected 0", user_latch); end
    cmp_cnt++; if (key_clear !== 1'b0) begin fail_cnt++; $display("FAIL reset_clear: got %b expected 0", key_clear); end
    cmp_cnt++; if (key_busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b expected 0", key_busy); end
    reset = 1'b1;
    ones = 4'b1111;
    for (int j = 0; j < 16; j++) begin
      exp_row = ones;
      exp_row[(j / 4) % 4] = 1'b0;
      cmp_cnt++;
      if (row_n !== exp_row) begin
        fail_cnt++;
        $display("FAIL scan_rotate[%0d]: got %b expected %b", j, row_n, exp_row);
      end
      tick();
    end
    $display("test_reset: reset values and 16-cycle row rotation checked");
  endtask

  task automatic test_hold_5();
    int base;
    int n;
    bit ok;
    base = latch_cnt;
    keys = '0;
    keys[5] = 1'b1;
    wait_row(4'b1101, ok);
    cmp_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL hold5_row1: got %b expected 1", ok); end
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (user_latch) begin
        n = i;
        break;
      end
    end
    cmp_cnt++; if (n !== 11) begin fail_cnt++; $display("FAIL hold5_latency: got %0d cycles after row1 drive expected 11", n); end
    cmp_cnt++; if (user_digit !== 4'd5) begin fail_cnt++; $display("FAIL hold5_digit: got %0d expected 5", user_digit); end
    repeat (40) tick();
    cmp_cnt++; if (latch_cnt - base !== 1) begin fail_cnt++; $display("FAIL hold5_single_pulse: got %0d expected 1", latch_cnt - base); end
    cmp_cnt++; if (key_busy !== 1'b1) begin fail_cnt++; $display("FAIL hold5_busy_held: got %b expected 1", key_busy); end
    keys = '0;
    wait_idle(ok);
    cmp_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL hold5_release: got busy %b expected 0", key_busy); end
    $display("test_hold_5: latch after %0d cycles, digit %0d", n, user_digit);
  endtask

  task automatic test_bounce_7();
    int base;
    bit ok;
    base = latch_cnt;
    keys = '0;
    wait_row(4'b1011, ok);
    for (int k = 0; k < 4; k++) begin
      keys[8] = 1'b1;
      repeat (3) tick();
      keys[8] = 1'b0;
      repeat (2) tick();
    end
    cmp_cnt++; if (latch_cnt !== base) begin fail_cnt++; $display("FAIL bounce7_no_early_latch: got %0d expected %0d", latch_cnt, base); end
    keys[8] = 1'b1;
    for (int i = 0; i < 60 && latch_cnt == base; i++) tick();
    repeat (20) tick();
    cmp_cnt++; if (latch_cnt - base !== 1) begin fail_cnt++; $display("FAIL bounce7_latch_count: got %0d expected 1", latch_cnt - base); end
    cmp_cnt++; if (last_digit !== 4'd7) begin fail_cnt++; $display("FAIL bounce7_digit: got %0d expected 7", last_digit); end
    keys = '0;
    wait_idle(ok);
    cmp_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL bounce7_release: got busy %b expected 0", key_busy); end
    $display("test_bounce_7: %0d latch(es), digit %0d", latch_cnt - base, last_digit);
  endtask

  task automatic test_ghost();
    int base;
    int changes;
    bit busy_seen;
    bit ok;
    logic [3:0] prev_row;
    base = latch_cnt;
    busy_seen = 1'b0;
    changes = 0;
    keys = '0;
    keys[1] = 1'b1;
    keys[2] = 1'b1;
    prev_row = row_n;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (key_busy) busy_seen = 1'b1;
      if (row_n != prev_row) changes++;
      prev_row = row_n;
    end
    cmp_cnt++; if (busy_seen !== 1'b0) begin fail_cnt++; $display("FAIL ghost_busy: got %b expected 0", busy_seen); end
    cmp_cnt++; if (latch_cnt !== base) begin fail_cnt++; $display("FAIL ghost_latch: got %0d expected %0d", latch_cnt, base); end
    cmp_cnt++; if (changes < 8) begin fail_cnt++; $display("FAIL ghost_scanning: got %0d row changes expected >= 8", changes); end
    keys = '0;
    keys[3] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (key_busy) begin
        ok = 1'b1;
        break;
      end
    end
    cmp_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL keyA_busy: got %b expected 1", ok); end
    repeat (30) tick();
    keys = '0;
    wait_idle(ok);
    cmp_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL keyA_release: got busy %b expected 0", key_busy); end
    cmp_cnt++; if (latch_cnt !== base) begin fail_cnt++; $display("FAIL keyA_no_latch: got %0d expected %0d", latch_cnt, base); end
    $display("test_ghost: %0d row changes with 2+3 held, key A busy without latch", changes);
  endtask

  task automatic test_star();
    int base_l;
    int base_c;
    bit ok;
    base_l = latch_cnt;
    base_c = clear_cnt;
    keys = '0;
    keys[12] = 1'b1;
    for (int i = 0; i < 30 && !key_busy; i++) tick();
    repeat (30) tick();
    cmp_cnt++; if (clear_cnt - base_c !== EXP_CLEAR) begin fail_cnt++; $display("FAIL star_clear: got %0d expected %0d", clear_cnt - base_c, EXP_CLEAR); end
    cmp_cnt++; if (latch_cnt !== base_l) begin fail_cnt++; $display("FAIL star_no_latch: got %0d expected %0d", latch_cnt, base_l); end
    cmp_cnt++; if (user_digit !== 4'd7) begin fail_cnt++; $display("FAIL star_digit_kept: got %0d expected 7", user_digit); end
    keys = '0;
    wait_idle(ok);
    cmp_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL star_release: got busy %b expected 0", key_busy); end
    $display("test_star: %0d clear pulse(s)", clear_cnt - base_c);
  endtask

  task automatic test_reset_mid_debounce();
    int base;
    bit ok;
    base = latch_cnt;
    keys = '0;
    keys[5] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (key_busy) begin
        ok = 1'b1;
        break;
      end
    end
    cmp_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL midrst_enter_debounce: got %b expected 1", ok); end
    repeat (3) tick();
    reset = 1'b0;
    #1;
    cmp_cnt++; if (row_n !== 4'b1110) begin fail_cnt++; $display("FAIL midrst_row_n: got %b expected 1110", row_n); end
    cmp_cnt++; if (key_busy !== 1'b0) begin fail_cnt++; $display("FAIL midrst_busy: got %b expected 0", key_busy); end
    cmp_cnt++; if (user_digit !== 4'd0) begin fail_cnt++; $display("FAIL midrst_digit: got %0d expected 0", user_digit); end
    cmp_cnt++; if (user_latch !== 1'b0) begin fail_cnt++; $display("FAIL midrst_latch: got %b expected 0", user_latch); end
    keys = '0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (40) tick();
    cmp_cnt++; if (latch_cnt !== base) begin fail_cnt++; $display("FAIL midrst_no_latch: got %0d expected %0d", latch_cnt, base); end
    cmp_cnt++; if (key_busy !== 1'b0) begin fail_cnt++; $display("FAIL midrst_idle: got %b expected 0", key_busy); end
    $display("test_reset_mid_debounce: outputs cleared, no latch afterwards");
  endtask

  task automatic test_release_window_0();
    int base;
    bit ok;
    base = latch_cnt;
    keys = '0;
    keys[13] = 1'b1;
    for (int i = 0; i < 60 && latch_cnt == base; i++) tick();
    cmp_cnt++; if (latch_cnt - base !== 1) begin fail_cnt++; $display("FAIL zero_first_latch: got %0d expected 1", latch_cnt - base); end
    cmp_cnt++; if (last_digit !== 4'd0) begin fail_cnt++; $display("FAIL zero_first_digit: got %0d expected 0", last_digit); end
    keys[13] = 1'b0;
    repeat (5) tick();
    keys[13] = 1'b1;
    repeat (20) tick();
    cmp_cnt++; if (latch_cnt - base !== 1) begin fail_cnt++; $display("FAIL zero_repress_in_release: got %0d expected 1", latch_cnt - base); end
    cmp_cnt++; if (key_busy !== 1'b1) begin fail_cnt++; $display("FAIL zero_release_extended: got %b expected 1", key_busy); end
    keys = '0;
    wait_idle(ok);
    cmp_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL zero_release_done: got busy %b expected 0", key_busy); end
    keys[13] = 1'b1;
    for (int i = 0; i < 60 && latch_cnt == base + 1; i++) tick();
    cmp_cnt++; if (latch_cnt - base !== 2) begin fail_cnt++; $display("FAIL zero_second_latch: got %0d expected 2", latch_cnt - base); end
    cmp_cnt++; if (last_digit !== 4'd0) begin fail_cnt++; $display("FAIL zero_second_digit: got %0d expected 0", last_digit); end
    keys = '0;
    wait_idle(ok);
    $display("test_release_window_0: %0d latches for two separated presses", latch_cnt - base);
  endtask

  task automatic test_pulse_rules();
    cmp_cnt++; if (overlap_seen !== 1'b0) begin fail_cnt++; $display("FAIL pulse_overlap: got %b expected 0", overlap_seen); end
    cmp_cnt++; if (consec_seen !== 1'b0) begin fail_cnt++; $display("FAIL pulse_consecutive: got %b expected 0", consec_seen); end
    $display("test_pulse_rules: %0d latches and %0d clears observed in total", latch_cnt, clear_cnt);
  endtask

  initial begin
    test_reset();
    test_hold_5();
    test_bounce_7();
    test_ghost();
    test_star();
    test_reset_mid_debounce();
    test_release_window_0();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
